// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, R/W and ACK
// bit values, and the address-match helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6
  } slv_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;

  // General call (address 0) never matches, whatever the own address is.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
    return (addr_byte[7:1] == own_addr) && (addr_byte[7:1] != 7'd0);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus input conditioning: synchronizes SCL/SDA, keeps one registered copy and
// decodes single-cycle scl_rise / scl_fall / START / STOP events.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_p_q;
  logic                   sda_p_q;

  // Idle bus level is high, so every stage resets to 1 to avoid a false event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_q      <= scl_sync_q[SYNC_STAGES-1];
      sda_q      <= sda_sync_q[SYNC_STAGES-1];
      scl_p_q    <= scl_q;
      sda_p_q    <= sda_q;
    end
  end

  assign start_o    = scl_q & scl_p_q & sda_p_q & ~sda_q;
  assign stop_o     = scl_q & scl_p_q & ~sda_p_q & sda_q;
  assign scl_rise_o = scl_q & ~scl_p_q & ~(start_o | stop_o);
  assign scl_fall_o = ~scl_q & scl_p_q & ~(start_o | stop_o);
  assign sda_o      = sda_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint: address match with ACK, write bytes handed to local logic,
// read bytes fetched from local logic and shifted out on an open-drain SDA.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);

  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic       sda_s;

  slv_state_t state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic       armed_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_load_q;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk_i      (clk_in),
    .rst_i      (reset_in),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s),
    .sda_o      (sda_s)
  );

  // Protocol FSM with shift register, bit counter and registered outputs.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      rw_q       <= I2C_RW_WRITE;
      armed_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      if (stop_s) begin
        state_q   <= IDLE;
        bit_cnt_q <= 3'd0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (start_s) begin
        state_q   <= ADDR;
        bit_cnt_q <= 3'd0;
        armed_q   <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            bit_cnt_q <= 3'd0;
          end
          // The SCL fall that completes START carries no bit: wait for a rise first.
          ADDR: begin
            if (scl_rise_s) begin
              shift_q <= {shift_q[6:0], sda_s};
              armed_q <= 1'b1;
            end else if (scl_fall_s && armed_q) begin
              armed_q <= 1'b0;
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= 3'd0;
                if (addr_match(shift_q, SLAVE_ADDR)) begin
                  state_q  <= ADDR_ACK;
                  sda_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  rw_q     <= shift_q[0];
                end else begin
                  state_q <= IDLE;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall_s) begin
              bit_cnt_q <= 3'd0;
              if (rw_q == I2C_RW_READ) begin
                tx_load_q <= 1'b1;
                shift_q   <= tx_data;
                sda_oe_q  <= ~tx_data[7];
                state_q   <= RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise_s) begin
              shift_q <= {shift_q[6:0], sda_s};
              if (bit_cnt_q == 3'd7) begin
                rx_data_q  <= {shift_q[6:0], sda_s};
                rx_valid_q <= 1'b1;
              end
            end else if (scl_fall_s) begin
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= 3'd0;
                sda_oe_q  <= 1'b1;
                state_q   <= WR_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall_s) begin
              bit_cnt_q <= 3'd0;
              sda_oe_q  <= 1'b0;
              state_q   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall_s) begin
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q <= 3'd0;
                sda_oe_q  <= 1'b0;
                state_q   <= RD_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                sda_oe_q  <= ~shift_q[6];
                shift_q   <= {shift_q[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise_s) begin
              if (sda_s != I2C_ACK) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
              end
            end else if (scl_fall_s) begin
              tx_load_q <= 1'b1;
              shift_q   <= tx_data;
              sda_oe_q  <= ~tx_data[7];
              bit_cnt_q <= 3'd0;
              state_q   <= RD_DATA;
            end
          end
          default: begin
            state_q  <= IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: open-drain bus master model (SCL = clk/16) with a
// transaction-level expectation model, directed scenarios and random transfers.
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       scl_bus;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_plan[$];
  logic [7:0] wr_plan[$];
  logic [7:0] rd_got[$];
  int         load_cnt = 0;
  int         exp_load_cnt = 0;
  logic [7:0] last_rx = 8'h00;

  always #5 clk = ~clk;

  assign scl_bus = m_scl;
  assign sda_bus = m_sda & ~sda_oe;

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .scl_in   (scl_bus),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Local-logic side: every rx_valid must match the next byte the master wrote;
  // every tx_load hands over the presented byte, which becomes the next read expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        if (exp_rx.size() == 0) check("rx_spurious", 32'(rx_valid), 32'd0);
        else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      if (tx_load === 1'b1) begin
        load_cnt++;
        exp_tx.push_back(tx_data);
        tx_data = (tx_plan.size() > 0) ? tx_plan.pop_front() : 8'($urandom);
      end
    end
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bit_xfer(input logic b, output logic seen);
    tick(4); m_sda = b;
    tick(4); m_scl = 1'b1;
    tick(4); seen = sda_bus;
    tick(4); m_scl = 1'b0;
  endtask

  task automatic start_cond();
    if (m_scl) begin
      tick(4); m_sda = 1'b0;
      tick(4); m_scl = 1'b0;
    end else begin
      tick(4); m_sda = 1'b1;
      tick(4); m_scl = 1'b1;
      tick(4); m_sda = 1'b0;
      tick(4); m_scl = 1'b0;
    end
  endtask

  task automatic stop_cond();
    tick(4); m_sda = 1'b0;
    tick(4); m_scl = 1'b1;
    tick(4); m_sda = 1'b1;
    tick(8);
    check("busy_after_stop", 32'(busy), 32'd0);
    check("sda_oe_after_stop", 32'(sda_oe), 32'd0);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic       s;
    logic [7:0] seen;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(b[i], s);
      seen[i] = s;
    end
    check({tag, "_bus"}, 32'(seen), 32'(b));
    bit_xfer(1'b1, s);
    check({tag, "_ack"}, 32'(s), exp_ack ? 32'd0 : 32'd1);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      got[i] = s;
    end
    bit_xfer(master_ack ? 1'b0 : 1'b1, s);
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rd, output logic acked);
    start_cond();
    acked = (a == 7'h50);
    write_byte({a, rd}, acked, "addr");
    check("busy_after_addr", 32'(busy), 32'(acked));
  endtask

  task automatic txn_write(input logic [6:0] a, input int n);
    logic       ok;
    logic [7:0] b;
    addr_phase(a, 1'b0, ok);
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        b = (wr_plan.size() > 0) ? wr_plan.pop_front() : 8'($urandom);
        exp_rx.push_back(b);
        write_byte(b, 1'b1, "wr_data");
        last_rx = b;
      end
    end
    stop_cond();
  endtask

  task automatic txn_read(input logic [6:0] a, input int n);
    logic       ok;
    logic [7:0] got;
    rd_got.delete();
    addr_phase(a, 1'b1, ok);
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        read_byte(k < n - 1, got);
        rd_got.push_back(got);
        if (exp_tx.size() == 0) check("rd_load_missing", 32'(exp_tx.size()), 32'd1);
        else check("rd_data", 32'(got), 32'(exp_tx.pop_front()));
      end
      exp_load_cnt += n;
    end
    stop_cond();
    check("tx_load_count", 32'(load_cnt), 32'(exp_load_cnt));
  endtask

  initial begin
    logic       ok;
    logic       s;
    logic [7:0] b;
    logic [3:0] hi;
    int         loads_before;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
    tick(5);
    check("reset_sda_oe", 32'(sda_oe), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_tx_load", 32'(tx_load), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick(8);

    // 1: plain write of 0xA5
    wr_plan.push_back(8'hA5);
    txn_write(7'h50, 1);
    check("t1_rx_data", 32'(rx_data), 32'h0000_00A5);

    // 2: foreign address ignored, then our address via repeated START
    start_cond();
    write_byte(8'hA2, 1'b0, "t2_addr");
    check("t2_busy", 32'(busy), 32'd0);
    txn_write(7'h50, 1);

    // 3: read 0x3C then 0xC3, master ACK then NACK
    loads_before = load_cnt;
    tx_data = 8'h3C;
    tx_plan.push_back(8'hC3);
    txn_read(7'h50, 2);
    check("t3_byte0", (rd_got.size() > 0) ? 32'(rd_got[0]) : 32'hFFFF_FFFF, 32'h0000_003C);
    check("t3_byte1", (rd_got.size() > 1) ? 32'(rd_got[1]) : 32'hFFFF_FFFF, 32'h0000_00C3);
    check("t3_loads", 32'(load_cnt - loads_before), 32'd2);

    // 4: write 0x12, repeated START into a read
    addr_phase(7'h50, 1'b0, ok);
    exp_rx.push_back(8'h12);
    write_byte(8'h12, 1'b1, "t4_data");
    last_rx = 8'h12;
    check("t4_rx_data", 32'(rx_data), 32'h0000_0012);
    txn_read(7'h50, 1);

    // 5: reset while the target drives a 0 in the middle of a read byte
    tx_data = 8'h96;
    addr_phase(7'h50, 1'b1, ok);
    for (int i = 3; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      hi[i] = s;
    end
    check("t5_high_nibble", 32'(hi), 32'h0000_0009);
    tick(6);
    check("t5_driving_zero", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_async_release", 32'(sda_oe), 32'd0);
    m_scl = 1'b1; m_sda = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(8);
    check("t5_busy_after_reset", 32'(busy), 32'd0);
    if (exp_tx.size() > 0) void'(exp_tx.pop_front());
    exp_load_cnt += 1;
    last_rx = 8'h00;
    txn_write(7'h50, 1);

    // 6: write aborted by STOP after 5 data bits
    addr_phase(7'h50, 1'b0, ok);
    b = 8'($urandom);
    exp_rx.push_back(b);
    write_byte(b, 1'b1, "t6_full");
    last_rx = b;
    for (int i = 0; i < 5; i++) bit_xfer(1'($urandom), s);
    stop_cond();
    check("t6_rx_kept", 32'(rx_data), 32'(last_rx));

    // General call is never acknowledged
    txn_write(7'h00, 1);

    // Random traffic
    for (int t = 0; t < 20; t++) begin
      logic [6:0] a;
      int         n;
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) txn_read(a, n);
      else txn_write(a, n);
    end

    tick(10);
    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    check("final_rx_data", 32'(rx_data), 32'(last_rx));
    check("final_tx_load_count", 32'(load_cnt), 32'(exp_load_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
